mw_lsu_ctrl: RTL and testbench
==============================

// Module: mw_lsu_ctrl
// PURPOSE
//  Parametrised stage-3 memory/writeback controller, successor to the combinational MW decode.
//  Decodes opcode/funct3 and aligns store byte-lanes to the address offset.
//  Runs a req/gnt/rvalid handshake to data memory with timeout, and extracts and sign-extends loads.
//  Produces a registered writeback. Sits between the EX pipeline register and the regfile write port;
//  in_ready low is the pipeline stall.
// PARAMETERS
//  DATA_W       32   data/regfile width; 32 or 64 only (64 enables LD/SD, LWU)
//  ADDR_W       32   data-memory byte address width
//  TIMEOUT_CYC  255  max cycles in REQ+WAIT before abort; must be >=2
// PORTS
//  clk          in   1          single clock, all state on rising edge
//  rst_n        in   1          asynchronous, active-low reset
//  in_valid     in   1          EX presents an instruction
//  in_ready     out  1          controller accepts (high only in IDLE)
//  opcode       in   7          RV opcode
//  funct3       in   3          RV funct3 (size [1:0], unsigned [2])
//  addr         in   ADDR_W     effective address (ALU result for ld/st)
//  alu_result   in   DATA_W     ALU output (writeback for ALU/LUI/AUIPC)
//  pc4          in   DATA_W     PC+4 (writeback for JAL/JALR)
//  store_data   in   DATA_W     rs2, unaligned (LSB-justified)
//  mem_req      out  1          request valid; held until mem_gnt
//  mem_gnt      in   1          memory accepts request this cycle
//  mem_we       out  1          1=store, 0=load
//  mem_addr     out  ADDR_W     word-aligned address (offset bits zeroed)
//  mem_wdata    out  DATA_W     store data shifted to lane
//  mem_wmask    out  DATA_W/8   byte enables, shifted by offset; all-ones-per-size for loads
//  mem_rvalid   in   1          load data valid; >=1 cycle after mem_gnt
//  mem_rdata    in   DATA_W     raw aligned word
//  wb_valid     out  1          one-cycle writeback pulse
//  wb_we        out  1          regfile write enable (qualified by wb_valid)
//  wb_data      out  DATA_W     writeback value
//  wb_err       out  2          0 none, 1 misaligned/illegal size, 2 timeout
// BEHAVIOUR
//  Reset: state=IDLE; mem_req, mem_we, wb_valid, wb_we=0; mem_addr, mem_wdata, mem_wmask, wb_data=0;
//   wb_err=0; timeout count=0. Async assert aborts any transaction, drops mem_req immediately.
//  FSM IDLE -> REQ -> (WAIT) -> IDLE. in_ready = (state==IDLE).
//  IDLE, in_valid:
//   - ALU/LUI/AUIPC/JAL/JALR: next cycle wb_valid=1, wb_we=1, data alu_result|pc4. Stay IDLE
//     (1 op/cycle, latency 1).
//   - BRANCH/unknown opcode: next cycle wb_valid=1, wb_we=0.
//   - LOAD/STORE: size S=1<<funct3[1:0]; off=addr[log2(DATA_W/8)-1:0].
//     - Illegal: size D with DATA_W=32, or off%S!=0. No request issued; next cycle wb_valid=1,
//       wb_we=0, wb_err=1.
//     - Legal: latch mem_* outputs, go REQ. mask=((1<<S)-1)<<off; wdata=store_data<<(8*off).
//  REQ: mem_req=1; outputs stable until gnt.
//   - Store gnt -> IDLE; next cycle wb_valid=1, wb_we=0.
//   - Load gnt -> WAIT. mem_rvalid in REQ is ignored.
//  WAIT: on mem_rvalid, take bytes [off..off+S-1] of mem_rdata; zero-extend if funct3[2], else
//   sign-extend to DATA_W. -> IDLE; next cycle wb_valid=1, wb_we=1.
//  mem_req drops the cycle after gnt.
//  Timeout: counter clears on entering REQ and increments each cycle in REQ/WAIT. When it reaches
//   TIMEOUT_CYC: -> IDLE, mem_req=0, next cycle wb_valid=1, wb_we=0, wb_err=2.
//   gnt/rvalid in the expiry cycle still win over timeout. Late mem_rvalid in IDLE is dropped.
//  wb_valid is a single-cycle pulse; wb_data/wb_err hold until the next pulse.
//  Single outstanding access; no back-pressure on writeback.
// TESTING
//  1 ALU stream 4 back-to-back, alu_result=1..4 -> wb_valid 4 consecutive cycles, wb_data 1..4,
//    in_ready always 1.
//  2 SB addr=0x1003 data=0xAB, gnt at 2nd REQ cycle -> mem_addr=0x1000, mem_wmask=4'b1000,
//    mem_wdata=0xAB000000; wb_valid, wb_we=0.
//  3 LB addr=0x2002, rdata=0x0080_0000 two cycles after gnt -> wb_data=0xFFFFFF80;
//    LBU same -> 0x00000080.
//  4 LW addr=0x2001 -> no mem_req; wb_err=1, wb_we=0 one cycle later.
//  5 LW with no rvalid, TIMEOUT_CYC=8 -> wb_err=2 after 8 cycles. Late rvalid ignored;
//    next op accepted normally.
//  6 rst_n low during WAIT -> mem_req=0, wb_valid=0 immediately; after release in_ready=1, no stray wb.

Source files
------------

// File: rtl/mw_lsu_ctrl.sv
// Stage-3 memory/writeback controller: decodes the EX instruction, runs the data-memory
// req/gnt/rvalid handshake with a timeout, and produces a registered one-cycle writeback.
`default_nettype none

module mw_lsu_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic [DATA_W-1:0]   pc4,
  input  logic [DATA_W-1:0]   store_data,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                wb_valid,
  output logic                wb_we,
  output logic [DATA_W-1:0]   wb_data,
  output logic [1:0]          wb_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_OPIMM   = 7'b0010011;
  localparam logic [6:0] OP_OP      = 7'b0110011;
  localparam logic [6:0] OP_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OP_OP32    = 7'b0111011;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [OFF_W-1:0]    off_q;
  logic [1:0]          sz_q;
  logic                uns_q;
  logic                mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [STRB_W-1:0]   mem_wmask_q;
  logic                wb_valid_q, wb_we_q;
  logic [DATA_W-1:0]   wb_data_q;
  logic [1:0]          wb_err_q;

  logic                is_ld, is_st, is_wb, is_jmp, illegal, expired;
  logic [1:0]          sz;
  logic [OFF_W-1:0]    off;

  function automatic logic [STRB_W-1:0] lane_mask(input logic [1:0] s, input logic [OFF_W-1:0] o);
    logic [STRB_W-1:0] base;
    case (s)
      2'd0:    base = STRB_W'(1);
      2'd1:    base = STRB_W'(3);
      2'd2:    base = STRB_W'(15);
      default: base = '1;
    endcase
    return base << o;
  endfunction

  // Shift the addressed bytes down to bit 0, then zero- or sign-extend by access size.
  function automatic logic [DATA_W-1:0] extract_load(input logic [DATA_W-1:0] raw,
                                                     input logic [OFF_W-1:0]  o,
                                                     input logic [1:0]        s,
                                                     input logic              u);
    logic [DATA_W-1:0]  sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    sh = raw >> {o, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    w  = sh[31:0];
    case (s)
      2'd0:    return u ? DATA_W'(sh[7:0])  : DATA_W'(b);
      2'd1:    return u ? DATA_W'(sh[15:0]) : DATA_W'(h);
      2'd2:    return u ? DATA_W'(sh[31:0]) : DATA_W'(w);
      default: return sh;
    endcase
  endfunction

  always_comb begin
    is_ld   = (opcode == OP_LOAD);
    is_st   = (opcode == OP_STORE);
    is_jmp  = (opcode == OP_JAL) || (opcode == OP_JALR);
    is_wb   = is_jmp || (opcode == OP_OP) || (opcode == OP_OPIMM) || (opcode == OP_LUI) ||
              (opcode == OP_AUIPC) || (opcode == OP_OP32) || (opcode == OP_OPIMM32);
    sz      = funct3[1:0];
    off     = addr[OFF_W-1:0];
    // Unsigned variant of the full-width load, and any unsigned store, have no encoding.
    illegal = ((DATA_W == 32) && (sz == 2'd3)) ||
              (funct3[2] && (is_st || (sz == 2'(OFF_W)))) ||
              ((off & OFF_W'((1 << sz) - 1)) != '0);
    expired = (cnt_q >= CNT_W'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      off_q       <= '0;
      sz_q        <= '0;
      uns_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_data_q   <= '0;
      wb_err_q    <= ERR_NONE;
    end else begin
      wb_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if ((is_ld || is_st) && !illegal) begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_st;
              mem_addr_q  <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_wdata_q <= store_data << {off, 3'b000};
              mem_wmask_q <= lane_mask(sz, off);
              off_q       <= off;
              sz_q        <= sz;
              uns_q       <= funct3[2];
              cnt_q       <= '0;
              state_q     <= S_REQ;
            end else begin
              wb_valid_q <= 1'b1;
              wb_we_q    <= is_wb;
              wb_err_q   <= (is_ld || is_st) ? ERR_ILLEGAL : ERR_NONE;
              if (is_wb) wb_data_q <= is_jmp ? pc4 : alu_result;
            end
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            if (mem_we_q) begin
              state_q    <= S_IDLE;
              wb_valid_q <= 1'b1;
              wb_we_q    <= 1'b0;
              wb_err_q   <= ERR_NONE;
            end else begin
              state_q <= S_WAIT;
            end
          end else if (expired) begin
            mem_req_q  <= 1'b0;
            state_q    <= S_IDLE;
            wb_valid_q <= 1'b1;
            wb_we_q    <= 1'b0;
            wb_err_q   <= ERR_TIMEOUT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_rvalid) begin
            state_q    <= S_IDLE;
            wb_valid_q <= 1'b1;
            wb_we_q    <= 1'b1;
            wb_data_q  <= extract_load(mem_rdata, off_q, sz_q, uns_q);
            wb_err_q   <= ERR_NONE;
          end else if (expired) begin
            state_q    <= S_IDLE;
            wb_valid_q <= 1'b1;
            wb_we_q    <= 1'b0;
            wb_err_q   <= ERR_TIMEOUT;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign wb_valid  = wb_valid_q;
  assign wb_we     = wb_we_q;
  assign wb_data   = wb_data_q;
  assign wb_err    = wb_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mw_lsu_ctrl.sv
// Directed bench for mw_lsu_ctrl: table of single-cycle ops plus hand sequences for
// store/load handshakes, timeout and asynchronous reset.
`timescale 1ns/1ps

module tb_mw_lsu_ctrl;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [AW-1:0] addr;
  logic [DW-1:0] alu_result, pc4, store_data;
  logic          mem_req, mem_gnt, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wmask;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          wb_valid, wb_we;
  logic [DW-1:0] wb_data;
  logic [1:0]    wb_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mw_lsu_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .addr(addr), .alu_result(alu_result),
    .pc4(pc4), .store_data(store_data), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_data(wb_data), .wb_err(wb_err)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] alu;
    logic [31:0] p4;
    logic        we;
    logic [31:0] data;
    logic [1:0]  err;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd);
    in_valid = 1'b1; opcode = op; funct3 = f3; addr = a; store_data = sd;
    step();
    in_valid = 1'b0;
  endtask

  // Load with gnt on the first REQ cycle and rvalid on the second cycle after gnt.
  task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [3:0] exp_mask, input logic [31:0] rd,
                         input logic [31:0] exp_data);
    issue(OP_LOAD, f3, a, 32'h0);
    chk({name, "_req"}, mem_req, 1);
    chk({name, "_we"}, mem_we, 0);
    chk({name, "_addr"}, mem_addr, {a[31:2], 2'b00});
    chk({name, "_mask"}, mem_wmask, exp_mask);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk({name, "_req_drop"}, mem_req, 0);
    chk({name, "_ready_wait"}, in_ready, 0);
    step();
    mem_rvalid = 1'b1; mem_rdata = rd;
    step();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk({name, "_wbv"}, wb_valid, 1);
    chk({name, "_wbwe"}, wb_we, 1);
    chk({name, "_data"}, wb_data, exp_data);
    chk({name, "_err"}, wb_err, 0);
  endtask

  initial begin
    int n;
    bit seen;

    vecs[0]  = '{OP_OP,     3'b000, 32'h0,    32'h1,        32'h0,   1'b1, 32'h1,        2'd0};
    vecs[1]  = '{OP_OP,     3'b000, 32'h0,    32'h2,        32'h0,   1'b1, 32'h2,        2'd0};
    vecs[2]  = '{OP_OPIMM,  3'b000, 32'h0,    32'h3,        32'h0,   1'b1, 32'h3,        2'd0};
    vecs[3]  = '{OP_OP,     3'b000, 32'h0,    32'h4,        32'h0,   1'b1, 32'h4,        2'd0};
    vecs[4]  = '{OP_LUI,    3'b000, 32'h0,    32'hABCDE000, 32'h0,   1'b1, 32'hABCDE000, 2'd0};
    vecs[5]  = '{OP_JAL,    3'b000, 32'h0,    32'hDEAD,     32'h104, 1'b1, 32'h104,      2'd0};
    vecs[6]  = '{OP_JALR,   3'b000, 32'h0,    32'hBEEF,     32'h208, 1'b1, 32'h208,      2'd0};
    vecs[7]  = '{OP_BRANCH, 3'b000, 32'h0,    32'h5,        32'h0,   1'b0, 32'h0,        2'd0};
    vecs[8]  = '{7'b1111111,3'b000, 32'h0,    32'h6,        32'h0,   1'b0, 32'h0,        2'd0};
    vecs[9]  = '{OP_LOAD,   3'b010, 32'h2001, 32'h0,        32'h0,   1'b0, 32'h0,        2'd1};
    vecs[10] = '{OP_LOAD,   3'b001, 32'h1001, 32'h0,        32'h0,   1'b0, 32'h0,        2'd1};
    vecs[11] = '{OP_LOAD,   3'b011, 32'h1000, 32'h0,        32'h0,   1'b0, 32'h0,        2'd1};
    vecs[12] = '{OP_STORE,  3'b010, 32'h1002, 32'h0,        32'h0,   1'b0, 32'h0,        2'd1};
    vecs[13] = '{OP_AUIPC,  3'b000, 32'h0,    32'h7,        32'h0,   1'b1, 32'h7,        2'd0};

    rst_n = 1'b0; in_valid = 1'b0; opcode = 7'h0; funct3 = 3'h0; addr = '0;
    alu_result = '0; pc4 = '0; store_data = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #23;
    chk("rst_ready", in_ready, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_wbdata", wb_data, 0);
    chk("rst_err", wb_err, 0);
    chk("rst_mask", mem_wmask, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Back-to-back single-cycle ops, one accepted per clock.
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1; opcode = vecs[i].op; funct3 = vecs[i].f3; addr = vecs[i].a;
      alu_result = vecs[i].alu; pc4 = vecs[i].p4;
      step();
      chk($sformatf("v%0d_wbv", i), wb_valid, 1);
      chk($sformatf("v%0d_wbwe", i), wb_we, vecs[i].we);
      chk($sformatf("v%0d_err", i), wb_err, vecs[i].err);
      if (vecs[i].we) chk($sformatf("v%0d_data", i), wb_data, vecs[i].data);
      chk($sformatf("v%0d_req", i), mem_req, 0);
      chk($sformatf("v%0d_ready", i), in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    chk("idle_wbv", wb_valid, 0);

    // SB to offset 3, grant on the second REQ cycle.
    issue(OP_STORE, 3'b000, 32'h1003, 32'hAB);
    chk("sb_req1", mem_req, 1);
    chk("sb_we", mem_we, 1);
    chk("sb_addr", mem_addr, 32'h1000);
    chk("sb_mask", mem_wmask, 4'b1000);
    chk("sb_wdata", mem_wdata, 32'hAB000000);
    chk("sb_ready", in_ready, 0);
    step();
    chk("sb_req2", mem_req, 1);
    chk("sb_wbv_early", wb_valid, 0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("sb_req_drop", mem_req, 0);
    chk("sb_wbv", wb_valid, 1);
    chk("sb_wbwe", wb_we, 0);
    chk("sb_err", wb_err, 0);
    chk("sb_ready_after", in_ready, 1);
    step();
    chk("sb_pulse", wb_valid, 0);

    do_load("lb",  3'b000, 32'h2002, 4'b0100, 32'h0080_0000, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 32'h2002, 4'b0100, 32'h0080_0000, 32'h00000080);
    do_load("lh",  3'b001, 32'h2002, 4'b1100, 32'h8001_0000, 32'hFFFF8001);
    do_load("lhu", 3'b101, 32'h2002, 4'b1100, 32'h8001_0000, 32'h00008001);
    do_load("lw",  3'b010, 32'h2004, 4'b1111, 32'h1234_5678, 32'h12345678);

    // Load granted but never answered: expect the timeout pulse 8 cycles after acceptance.
    issue(OP_LOAD, 3'b010, 32'h3000, 32'h0);
    n = 1;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      n++;
      step();
      if (wb_valid) seen = 1'b1;
    end
    chk("to_seen", seen, 1);
    chk("to_cycles", n, TO);
    chk("to_err", wb_err, 2);
    chk("to_wbwe", wb_we, 0);
    chk("to_ready", in_ready, 1);
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_rvalid = 1'b0;
    chk("late_rvalid_wbv", wb_valid, 0);
    in_valid = 1'b1; opcode = OP_OP; alu_result = 32'h55;
    step();
    in_valid = 1'b0;
    chk("post_to_wbv", wb_valid, 1);
    chk("post_to_data", wb_data, 32'h55);
    chk("post_to_err", wb_err, 0);

    // Asynchronous reset in the middle of a load's WAIT phase.
    issue(OP_LOAD, 3'b010, 32'h4000, 32'h0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("rw_ready_wait", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_req", mem_req, 0);
    chk("rw_wbv", wb_valid, 0);
    chk("rw_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    step();
    mem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rw_nostray%0d", k), wb_valid, 0);
      chk($sformatf("rw_ready%0d", k), in_ready, 1);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
